booth_mult_ctrl: RTL and testbench

BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

---
 rtl/booth_mult_ctrl_pkg.sv | 29 ++
 rtl/booth_digit_decode.sv | 34 +++
 rtl/booth_mult_ctrl.sv | 137 +++++++++++++
 tb/tb_booth_mult_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_ctrl_pkg.sv
// Shared types and constants for the radix-16 Booth multiplier controller.
// Pure declarations: no latency, no flow control.
package booth_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_A_ZERO = 3'd0;
    localparam logic [2:0] SEL_A_X1   = 3'd1;
    localparam logic [2:0] SEL_A_X2   = 3'd2;
    localparam logic [2:0] SEL_A_X4   = 3'd3;
    localparam logic [2:0] SEL_A_X8   = 3'd4;

    localparam logic [1:0] SEL_B_ZERO = 2'd0;
    localparam logic [1:0] SEL_B_X1   = 2'd1;
    localparam logic [1:0] SEL_B_X2   = 2'd2;

    localparam logic SEL_C_ZERO = 1'b0;
    localparam logic SEL_C_X1   = 1'b1;

    // ceil((width+1)/4): one extra bit so unsigned operands keep a zero top digit
    function automatic int digitsFor(input int width);
        return (width + 4) / 4;
    endfunction

endpackage

// File: rtl/booth_digit_decode.sv
// Radix-16 Booth digit decoder: 5-bit window to term selects and sign.
// Purely combinational, zero latency; no flow control.
module booth_digit_decode
    import booth_mult_ctrl_pkg::*;
(
    input  logic [4:0] window,
    output logic [2:0] selBoothA,
    output logic [1:0] selBoothB,
    output logic       selBoothC,
    output logic       sign
);

    logic signed [4:0] digit;
    logic [3:0]        mag;

    always_comb begin
        // {b3,b3,b2,b1,b0} is -8*b3+4*b2+2*b1+b0; then add b(-1)
        digit = $signed({window[4], window[4:1]}) + $signed({4'b0000, window[0]});
        sign  = digit[4];
        mag   = digit[4] ? ((~digit[3:0]) + 4'd1) : digit[3:0];

        selBoothA = SEL_A_ZERO;
        selBoothB = SEL_B_ZERO;
        selBoothC = SEL_C_ZERO;
        if (mag[3]) begin
            selBoothA = SEL_A_X8;
        end else begin
            selBoothA = mag[2] ? SEL_A_X4 : SEL_A_ZERO;
            selBoothB = mag[1] ? SEL_B_X2 : SEL_B_ZERO;
            selBoothC = mag[0] ? SEL_C_X1 : SEL_C_ZERO;
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-16 Booth multiply controller driving an external select datapath.
// Fixed DIGITS+1 cycle latency from Start to Done; Start outside IDLE is dropped, never queued.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = digitsFor(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Mcand,
    input  logic [WIDTH-1:0]     Mplier,
    input  logic [2*WIDTH-1:0]   BoothA,
    input  logic [2*WIDTH-1:0]   BoothB,
    input  logic [2*WIDTH-1:0]   BoothC,
    output logic [2*WIDTH-1:0]   A,
    output logic [2:0]           SelBoothA,
    output logic [1:0]           SelBoothB,
    output logic                 SelBoothC,
    output logic                 Sign,
    output logic                 Busy,
    output logic                 Done,
    output logic [WIDTH-1:0]     Hi,
    output logic [WIDTH-1:0]     Lo
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int MPL_W = 4 * DIGITS;
    localparam int EXT_W = MPL_W - WIDTH;
    localparam int IDX_W = $clog2(DIGITS + 1);

    state_t state, nextState;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcandExt;
    logic [ACC_W-1:0] stepSum;
    logic [MPL_W:0]   mplierExt;   // bit 0 is the implicit b(-1)
    logic [IDX_W-1:0] digitIdx;
    logic [IDX_W+1:0] shiftAmt;
    logic [4:0]       window;
    logic             lastDigit;
    logic             mcandSignBit;
    logic             mplierSignBit;

    logic [2:0] decSelA;
    logic [1:0] decSelB;
    logic       decSelC;
    logic       decSign;

    assign stepSum       = acc + BoothA + BoothB + BoothC;
    assign lastDigit     = (digitIdx == IDX_W'(DIGITS - 1));
    assign shiftAmt      = {digitIdx, 2'b00};
    assign window        = mplierExt[shiftAmt +: 5];
    assign mcandSignBit  = Signed & Mcand[WIDTH-1];
    assign mplierSignBit = Signed & Mplier[WIDTH-1];

    booth_digit_decode u_decode (
        .window    (window),
        .selBoothA (decSelA),
        .selBoothB (decSelB),
        .selBoothC (decSelC),
        .sign      (decSign)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (lastDigit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc       <= '0;
            mcandExt  <= '0;
            mplierExt <= '0;
            digitIdx  <= '0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcandExt  <= {{WIDTH{mcandSignBit}}, Mcand};
                        mplierExt <= {{EXT_W{mplierSignBit}}, Mplier, 1'b0};
                        acc       <= '0;
                        digitIdx  <= '0;
                    end
                end
                RUN: begin
                    acc      <= stepSum;
                    digitIdx <= digitIdx + 1'b1;
                    if (lastDigit) begin
                        {Hi, Lo} <= stepSum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Busy      = 1'b0;
        Done      = 1'b0;
        A         = '0;
        SelBoothA = SEL_A_ZERO;
        SelBoothB = SEL_B_ZERO;
        SelBoothC = SEL_C_ZERO;
        Sign      = 1'b0;
        case (state)
            RUN: begin
                Busy      = 1'b1;
                A         = mcandExt << shiftAmt;
                SelBoothA = decSelA;
                SelBoothB = decSelB;
                SelBoothC = decSelC;
                Sign      = decSign;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl with a behavioural select datapath beside it.
// Samples #1 after each rising edge; cycle 1 is the cycle after the Start edge.
module tb_booth_mult_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] Mcand = '0;
    logic [31:0] Mplier = '0;
    logic [63:0] BoothA, BoothB, BoothC, A;
    logic [2:0]  SelBoothA;
    logic [1:0]  SelBoothB;
    logic        SelBoothC, Sign, Busy, Done;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int errors = 0;

    int          doneCyc, doneCnt, busyCnt;
    logic [63:0] prod;

    always #5 Clk = ~Clk;

    booth_mult_ctrl #(.WIDTH(32), .DIGITS(9)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed),
        .Mcand(Mcand), .Mplier(Mplier),
        .BoothA(BoothA), .BoothB(BoothB), .BoothC(BoothC),
        .A(A), .SelBoothA(SelBoothA), .SelBoothB(SelBoothB), .SelBoothC(SelBoothC),
        .Sign(Sign), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    function automatic logic [63:0] term(input logic [63:0] a, input int sh, input logic neg);
        logic [63:0] t;
        t = a << sh;
        return neg ? (~t + 64'd1) : t;
    endfunction

    // Select datapath model: scaled multiplicand terms, all negated when Sign is set
    always_comb begin
        case (SelBoothA)
            3'd1:    BoothA = term(A, 0, Sign);
            3'd2:    BoothA = term(A, 1, Sign);
            3'd3:    BoothA = term(A, 2, Sign);
            3'd4:    BoothA = term(A, 3, Sign);
            default: BoothA = '0;
        endcase
        case (SelBoothB)
            2'd1:    BoothB = term(A, 0, Sign);
            2'd2:    BoothB = term(A, 1, Sign);
            default: BoothB = '0;
        endcase
        BoothC = SelBoothC ? term(A, 0, Sign) : 64'd0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic runOp(input logic sgn, input logic [31:0] mc, input logic [31:0] mp,
                         input int pulseCyc, input int rstCyc,
                         output int dCyc, output int dCnt, output int bCnt,
                         output logic [63:0] p);
        Signed = sgn;
        Mcand  = mc;
        Mplier = mp;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        dCyc = -1;
        dCnt = 0;
        bCnt = 0;
        p    = '0;
        for (int c = 1; c <= 30; c++) begin
            if (Busy) bCnt++;
            if (Done) begin
                dCnt++;
                if (dCyc < 0) begin
                    dCyc = c;
                    p    = {Hi, Lo};
                end
            end
            Start = (c == pulseCyc);
            if (c == rstCyc) begin
                Rst = 1'b1;
                #1;
                check("abort_busy", {63'd0, Busy}, 64'd0);
                check("abort_hilo", {Hi, Lo}, 64'd0);
                check("abort_a", A, 64'd0);
                @(negedge Clk);
                Rst = 1'b0;
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_a", A, 64'd0);
        check("rst_sels", {58'd0, SelBoothA, SelBoothB, SelBoothC}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // MULTU 3 x 5: timing and result
        runOp(1'b0, 32'd3, 32'd5, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("u3x5_done_cycle", 64'(doneCyc), 64'd10);
        check("u3x5_busy_cycles", 64'(busyCnt), 64'd9);
        check("u3x5_done_count", 64'(doneCnt), 64'd1);
        check("u3x5_prod", prod, 64'h0000_0000_0000_000F);

        runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("u_max_prod", prod, 64'hFFFF_FFFE_0000_0001);

        runOp(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("s_minsq_prod", prod, 64'h4000_0000_0000_0000);

        runOp(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("s_m1x2_prod", prod, 64'hFFFF_FFFF_FFFF_FFFE);

        runOp(1'b1, 32'hFFFF_FFFD, 32'd7, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("s_m3x7_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);

        runOp(1'b0, 32'hFFFF_FFFD, 32'd7, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("u_fffdx7_prod", prod, 64'h0000_0006_FFFF_FFEB);

        // Result holds in IDLE; idle outputs are zero
        repeat (3) @(posedge Clk);
        #1;
        check("hold_hilo", {Hi, Lo}, 64'h0000_0006_FFFF_FFEB);
        check("idle_a", A, 64'd0);
        check("idle_sign", {63'd0, Sign}, 64'd0);

        runOp(1'b0, 32'd0, 32'd0, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("zero_done_cycle", 64'(doneCyc), 64'd10);
        check("zero_prod", prod, 64'd0);

        // Per-digit decode with Mplier = 8
        Signed = 1'b0;
        Mcand  = 32'd3;
        Mplier = 32'd8;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("d0_selA", 64'(SelBoothA), 64'd4);
        check("d0_sign", {63'd0, Sign}, 64'd1);
        check("d0_a", A, 64'd3);
        @(posedge Clk); #1;
        check("d1_selC", {63'd0, SelBoothC}, 64'd1);
        check("d1_selAB", {59'd0, SelBoothA, SelBoothB}, 64'd0);
        check("d1_sign", {63'd0, Sign}, 64'd0);
        check("d1_a", A, 64'h30);
        for (int c = 0; c < 20 && !Done; c++) begin
            @(posedge Clk); #1;
        end
        check("d_done", {63'd0, Done}, 64'd1);
        check("d_prod", {Hi, Lo}, 64'h18);
        @(posedge Clk); #1;

        // Reset mid-run discards the operation, next op runs normally
        runOp(1'b0, 32'h1234_5678, 32'd9, 0, 5, doneCyc, doneCnt, busyCnt, prod);
        check("abort_no_done", 64'(doneCnt), 64'd0);
        runOp(1'b0, 32'd7, 32'd6, 0, 0, doneCyc, doneCnt, busyCnt, prod);
        check("post_rst_done_cycle", 64'(doneCyc), 64'd10);
        check("post_rst_prod", prod, 64'h2A);

        // Start during RUN is ignored and not queued
        runOp(1'b0, 32'd11, 32'd13, 4, 0, doneCyc, doneCnt, busyCnt, prod);
        check("ignore_done_count", 64'(doneCnt), 64'd1);
        check("ignore_prod", prod, 64'h8F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
